// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one outstanding req/ack bus transaction per op,
// single-cycle write-back for loads and pass-through ops, sticky bus timeout flag.
module mem_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_c_load,
  input  logic              i_c_store,
  input  logic              i_c_wb,
  input  logic [REG_W-1:0]  i_wb_sel,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_wb_valid,
  output logic [REG_W-1:0]  o_wb_sel,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_bus_err
);

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [REG_W-1:0] req_sel_q;
  logic             req_wb_q;

  logic accept;
  logic is_mem;
  logic timed_out;

  // Ready and req are pure state decodes so an async reset drops req at once.
  assign o_ready   = (state_q == StIdle);
  assign o_mem_req = (state_q == StReq);
  assign accept    = i_valid & o_ready;
  assign is_mem    = i_c_load | i_c_store;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CntLast);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_sel_q  <= '0;
      req_wb_q   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_wb_valid <= 1'b0;
      o_wb_sel   <= '0;
      o_wb_data  <= '0;
      o_bus_err  <= 1'b0;
    end else begin
      o_wb_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_mem) begin
              state_q    <= StReq;
              cnt_q      <= '0;
              o_mem_we   <= i_c_store;
              o_mem_addr <= i_addr;
              o_mem_data <= i_data;
              req_sel_q  <= i_wb_sel;
              // Store wins over load, so a store never writes back.
              req_wb_q   <= i_c_wb & ~i_c_store;
            end else if (i_c_wb) begin
              o_wb_valid <= 1'b1;
              o_wb_sel   <= i_wb_sel;
              o_wb_data  <= i_addr;
            end
          end
        end
        StReq: begin
          if (i_mem_ack) begin
            state_q <= StIdle;
            if (req_wb_q) begin
              o_wb_valid <= 1'b1;
              o_wb_sel   <= req_sel_q;
              o_wb_data  <= i_mem_data;
            end
          end else if (timed_out) begin
            state_q   <= StIdle;
            o_bus_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset-mid-load sequence,
// and randomized traffic checked against a transaction-level reference model.
module tb_mem_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid, c_load, c_store, c_wb, mem_ack;
  logic [DW-1:0] addr, data, mem_rdata;
  logic [RW-1:0] wb_sel;
  logic          ready, mem_req, mem_we, wb_valid, bus_err;
  logic [DW-1:0] mem_addr, mem_wdata, wb_data;
  logic [RW-1:0] wb_sel_o;

  int errors = 0;
  int checks = 0;

  mem_stage #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_addr     (addr),
    .i_data     (data),
    .i_c_load   (c_load),
    .i_c_store  (c_store),
    .i_c_wb     (c_wb),
    .i_wb_sel   (wb_sel),
    .o_mem_req  (mem_req),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_data (mem_wdata),
    .i_mem_ack  (mem_ack),
    .i_mem_data (mem_rdata),
    .o_wb_valid (wb_valid),
    .o_wb_sel   (wb_sel_o),
    .o_wb_data  (wb_data),
    .o_bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          v, ld, st, wb;
    logic [DW-1:0] addr, data;
    logic [RW-1:0] sel;
    logic          ack;
    logic [DW-1:0] mdat;
    logic          e_ready, e_req, e_we;
    logic [DW-1:0] e_addr, e_mdat;
    logic          e_wbv;
    logic [RW-1:0] e_sel;
    logic [DW-1:0] e_wbd;
    logic          e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic v, ld, st, wb, input logic [DW-1:0] a, d, input logic [RW-1:0] s,
    input logic ak, input logic [DW-1:0] md, input logic er, eq, ew,
    input logic [DW-1:0] ea, emd, input logic ewv, input logic [RW-1:0] es,
    input logic [DW-1:0] ewd, input logic ee);
    vec_t r;
    r.v = v; r.ld = ld; r.st = st; r.wb = wb; r.addr = a; r.data = d; r.sel = s;
    r.ack = ak; r.mdat = md; r.e_ready = er; r.e_req = eq; r.e_we = ew; r.e_addr = ea;
    r.e_mdat = emd; r.e_wbv = ewv; r.e_sel = es; r.e_wbd = ewd; r.e_err = ee;
    return r;
  endfunction

  // Reference model state: one pending bus op, counted in request cycles.
  bit            m_busy, m_we, m_wben, m_err, m_wbv;
  int            m_waited;
  logic [DW-1:0] m_addr, m_data, m_wbd;
  logic [RW-1:0] m_sel, m_wbsel;

  task automatic model_reset();
    m_busy = 0; m_we = 0; m_wben = 0; m_err = 0; m_wbv = 0; m_waited = 0;
    m_addr = '0; m_data = '0; m_wbd = '0; m_sel = '0; m_wbsel = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    m_wbv = 0;
    if (!m_busy) begin
      if (valid && (c_load || c_store)) begin
        m_busy = 1; m_we = c_store; m_addr = addr; m_data = data;
        m_sel = wb_sel; m_wben = c_wb && !c_store; m_waited = 1;
      end else if (valid && c_wb) begin
        m_wbv = 1; m_wbsel = wb_sel; m_wbd = addr;
      end
    end else if (mem_ack) begin
      m_busy = 0;
      if (m_wben) begin
        m_wbv = 1; m_wbsel = m_sel; m_wbd = mem_rdata;
      end
    end else if (m_waited == TO) begin
      m_busy = 0; m_err = 1;
    end else begin
      m_waited++;
    end
  endtask

  task automatic drive_idle();
    valid = 0; c_load = 0; c_store = 0; c_wb = 0; mem_ack = 0;
    addr = '0; data = '0; wb_sel = '0; mem_rdata = '0;
  endtask

  vec_t vecs[$];

  initial begin
    drive_idle();
    rst = 1'b1;
    #1;
    check("reset_ready", ready, 1);
    check("reset_req", mem_req, 0);
    check("reset_wbv", wb_valid, 0);
    check("reset_err", bus_err, 0);
    check("reset_wbdata", wb_data, 0);
    check("reset_addr", mem_addr, 0);
    step();
    step();
    rst = 1'b0;

    // Pass-through burst
    vecs.push_back(mk(1,0,0,1,'h0011,0,1,0,0, 1,0,0,0,0, 1,1,'h0011,0));
    vecs.push_back(mk(1,0,0,1,'h0022,0,2,0,0, 1,0,0,0,0, 1,2,'h0022,0));
    vecs.push_back(mk(1,0,0,1,'h0033,0,3,0,0, 1,0,0,0,0, 1,3,'h0033,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      1,0,0,0,0, 0,3,'h0033,0));
    // Load, ack after three request cycles
    vecs.push_back(mk(1,1,0,1,'h1234,0,5,0,0, 0,1,0,'h1234,0, 0,3,'h0033,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      0,1,0,'h1234,0, 0,3,'h0033,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      0,1,0,'h1234,0, 0,3,'h0033,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,'hBEEF, 1,0,0,0,0, 1,5,'hBEEF,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      1,0,0,0,0, 0,5,'hBEEF,0));
    // Store with both flags, immediate ack, no write-back
    vecs.push_back(mk(1,1,1,1,'h00F0,'hA5A5,6,0,0, 0,1,1,'h00F0,'hA5A5, 0,5,'hBEEF,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,'h7777, 1,0,0,0,0, 0,5,'hBEEF,0));
    // Timeout: four request cycles then abort
    vecs.push_back(mk(1,1,0,1,'h0400,0,4,0,0, 0,1,0,'h0400,0, 0,5,'hBEEF,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      0,1,0,'h0400,0, 0,5,'hBEEF,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      0,1,0,'h0400,0, 0,5,'hBEEF,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      0,1,0,'h0400,0, 0,5,'hBEEF,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      1,0,0,0,0, 0,5,'hBEEF,1));
    vecs.push_back(mk(1,1,0,1,'h0500,0,7,0,0, 0,1,0,'h0500,0, 0,5,'hBEEF,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,'h1357, 1,0,0,0,0, 1,7,'h1357,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      1,0,0,0,0, 0,7,'h1357,1));
    // Stall: second op held during REQ, accepted in the write-back cycle
    vecs.push_back(mk(1,1,0,1,'h0600,0,2,0,0, 0,1,0,'h0600,0, 0,7,'h1357,1));
    vecs.push_back(mk(1,0,1,0,'h0700,'h1111,0,0,0, 0,1,0,'h0600,0, 0,7,'h1357,1));
    vecs.push_back(mk(1,0,1,0,'h0700,'h1111,0,1,'h2468, 1,0,0,0,0, 1,2,'h2468,1));
    vecs.push_back(mk(1,0,1,0,'h0700,'h1111,0,0,0, 0,1,1,'h0700,'h1111, 0,2,'h2468,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,0,      1,0,0,0,0, 0,2,'h2468,1));
    // Ack while idle is ignored; pass-through without wb has no effect
    vecs.push_back(mk(0,0,0,0,0,0,0,1,'hFFFF, 1,0,0,0,0, 0,2,'h2468,1));
    vecs.push_back(mk(1,0,0,0,'h9999,0,6,0,0, 1,0,0,0,0, 0,2,'h2468,1));

    foreach (vecs[i]) begin
      valid = vecs[i].v; c_load = vecs[i].ld; c_store = vecs[i].st; c_wb = vecs[i].wb;
      addr = vecs[i].addr; data = vecs[i].data; wb_sel = vecs[i].sel;
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].mdat;
      step();
      check($sformatf("vec%0d_ready", i), ready, vecs[i].e_ready);
      check($sformatf("vec%0d_req", i), mem_req, vecs[i].e_req);
      if (vecs[i].e_req) begin
        check($sformatf("vec%0d_we", i), mem_we, vecs[i].e_we);
        check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
        if (vecs[i].e_we) check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_mdat);
      end
      check($sformatf("vec%0d_wbv", i), wb_valid, vecs[i].e_wbv);
      check($sformatf("vec%0d_wbsel", i), wb_sel_o, vecs[i].e_sel);
      check($sformatf("vec%0d_wbdata", i), wb_data, vecs[i].e_wbd);
      check($sformatf("vec%0d_err", i), bus_err, vecs[i].e_err);
    end

    // Reset in the middle of a load
    drive_idle();
    valid = 1; c_load = 1; c_wb = 1; addr = 'h0BAD; wb_sel = 1;
    step();
    drive_idle();
    check("rstmid_req_before", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_req", mem_req, 0);
    check("rstmid_ready", ready, 1);
    check("rstmid_err", bus_err, 0);
    check("rstmid_wbv", wb_valid, 0);
    mem_ack = 1; mem_rdata = 'hCAFE;
    step();
    rst = 1'b0;
    step();
    check("rstmid_wbv_after", wb_valid, 0);
    check("rstmid_req_after", mem_req, 0);
    check("rstmid_wbdata_after", wb_data, 0);

    // Randomized traffic against the reference model
    drive_idle();
    step();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      valid     = ($urandom_range(0, 1) == 1);
      c_load    = ($urandom_range(0, 2) == 0);
      c_store   = ($urandom_range(0, 3) == 0);
      c_wb      = ($urandom_range(0, 3) != 0);
      addr      = DW'($urandom);
      data      = DW'($urandom);
      wb_sel    = RW'($urandom);
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = DW'($urandom);
      model_edge();
      step();
      check($sformatf("rnd%0d_ready", n), ready, !m_busy);
      check($sformatf("rnd%0d_req", n), mem_req, m_busy);
      check($sformatf("rnd%0d_we", n), mem_we, m_we);
      check($sformatf("rnd%0d_addr", n), mem_addr, m_addr);
      check($sformatf("rnd%0d_wdata", n), mem_wdata, m_data);
      check($sformatf("rnd%0d_wbv", n), wb_valid, m_wbv);
      check($sformatf("rnd%0d_wbsel", n), wb_sel_o, m_wbsel);
      check($sformatf("rnd%0d_wbdata", n), wb_data, m_wbd);
      check($sformatf("rnd%0d_err", n), bus_err, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
